// File: rtl/qcv_pkg.sv
// Shared types and constants for the qcv load/store unit.
package qcv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    localparam logic [1:0] LSU_TYPE_B = 2'b00;
    localparam logic [1:0] LSU_TYPE_H = 2'b01;
    localparam logic [1:0] LSU_TYPE_W = 2'b10;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_GNT1,
        LSU_RV1,
        LSU_GNT2,
        LSU_RV2
    } lsu_state_e;

    // An access crosses a word boundary; the reserved type 11 behaves as a word.
    function automatic logic lsu_split(input logic [1:0] typ, input logic [1:0] off);
        case (typ)
            LSU_TYPE_B: return 1'b0;
            LSU_TYPE_H: return (off == 2'd3);
            default:    return (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/qcv_lsu_align.sv
// Byte-lane steering: byte enables per part, store-data rotation and
// load-data alignment with sign/zero extension.
module qcv_lsu_align
    import qcv_pkg::*;
(
    input  logic [1:0]      i_type,
    input  logic [1:0]      i_off,
    input  logic            i_part,
    input  logic            i_sign,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata1,
    input  logic [XLEN-1:0] i_rdata2,
    output logic [BE_W-1:0] o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [5:0]        w_shamt;
    logic [BE_W-1:0]   w_base;
    logic [2*BE_W-1:0] w_mask;
    logic [XLEN-1:0]   w_raw;

    always_comb begin
        w_shamt = {1'b0, i_off, 3'b000};

        case (i_type)
            LSU_TYPE_B: w_base = BE_BYTE;
            LSU_TYPE_H: w_base = BE_HALF;
            default:    w_base = BE_WORD;
        endcase

        // Upper nibble of the shifted mask holds the lanes spilling into part 2.
        w_mask = {{BE_W{1'b0}}, w_base} << i_off;
        o_be   = i_part ? w_mask[2*BE_W-1:BE_W] : w_mask[BE_W-1:0];

        o_wdata = (i_wdata << w_shamt) | (i_wdata >> (6'd32 - w_shamt));

        w_raw = XLEN'({i_rdata2, i_rdata1} >> w_shamt);
        case (i_type)
            LSU_TYPE_B: o_rdata = {{24{i_sign & w_raw[7]}}, w_raw[7:0]};
            LSU_TYPE_H: o_rdata = {{16{i_sign & w_raw[15]}}, w_raw[15:0]};
            default:    o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/qcv_lsu.sv
// Load/store unit: one outstanding access, misaligned accesses split into two
// word transactions on a req/gnt/rvalid data port.
module qcv_lsu
    import qcv_pkg::*;
#(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_type_i,
    input  logic            lsu_sign_ext_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_busy_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic [XLEN-1:0] data_addr_o,
    output logic            data_we_o,
    output logic [BE_W-1:0] data_be_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i,
    input  logic            data_err_i,
    output logic [XLEN-1:0] rf_wdata_lsu_o,
    output logic            rf_we_lsu_o,
    output logic            lsu_resp_valid_o,
    output logic            lsu_resp_err_o
);

    lsu_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata1;
    logic [1:0]      r_type;
    logic            r_we, r_sign, r_err_pend;

    logic            w_accept, w_reject, w_split, w_part2;
    logic [XLEN-1:0] w_base_addr, w_rdata1, w_rdata2, w_bus_wdata, w_ext;
    logic [BE_W-1:0] w_be;

    assign w_accept    = (r_state == LSU_IDLE) && lsu_req_i;
    assign w_reject    = w_accept && lsu_split(lsu_type_i, lsu_addr_i[1:0]) && !MISALIGNED_EN;
    assign w_split     = lsu_split(r_type, r_addr[1:0]);
    assign w_part2     = (r_state == LSU_GNT2) || (r_state == LSU_RV2);
    assign w_base_addr = {r_addr[XLEN-1:2], 2'b00};
    assign w_rdata1    = (r_state == LSU_RV2) ? r_rdata1 : data_rdata_i;
    assign w_rdata2    = (r_state == LSU_RV2) ? data_rdata_i : '0;

    qcv_lsu_align u_align (
        .i_type   (r_type),
        .i_off    (r_addr[1:0]),
        .i_part   (w_part2),
        .i_sign   (r_sign),
        .i_wdata  (r_wdata),
        .i_rdata1 (w_rdata1),
        .i_rdata2 (w_rdata2),
        .o_be     (w_be),
        .o_wdata  (w_bus_wdata),
        .o_rdata  (w_ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= LSU_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Request latches and the part-1 read buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata1   <= '0;
            r_type     <= LSU_TYPE_B;
            r_we       <= 1'b0;
            r_sign     <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= w_reject;
            if (w_accept) begin
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
                r_type  <= lsu_type_i;
                r_we    <= lsu_we_i;
                r_sign  <= lsu_sign_ext_i;
            end
            if (r_state == LSU_RV1 && data_rvalid_i) r_rdata1 <= data_rdata_i;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        lsu_busy_o       = (r_state != LSU_IDLE);
        data_req_o       = 1'b0;
        data_addr_o      = '0;
        data_we_o        = 1'b0;
        data_be_o        = '0;
        data_wdata_o     = '0;
        lsu_resp_valid_o = 1'b0;
        lsu_resp_err_o   = 1'b0;
        rf_we_lsu_o      = 1'b0;
        rf_wdata_lsu_o   = '0;

        case (r_state)
            LSU_IDLE: if (w_accept && !w_reject) w_state_nxt = LSU_GNT1;
            LSU_GNT1, LSU_GNT2: begin
                data_req_o   = 1'b1;
                data_addr_o  = w_part2 ? w_base_addr + 32'd4 : w_base_addr;
                data_we_o    = r_we;
                data_be_o    = w_be;
                data_wdata_o = w_bus_wdata;
                if (data_gnt_i) w_state_nxt = w_part2 ? LSU_RV2 : LSU_RV1;
            end
            LSU_RV1: begin
                if (data_rvalid_i) begin
                    if (data_err_i || !w_split) begin
                        lsu_resp_valid_o = 1'b1;
                        lsu_resp_err_o   = data_err_i;
                        w_state_nxt      = LSU_IDLE;
                    end else begin
                        w_state_nxt = LSU_GNT2;
                    end
                end
            end
            LSU_RV2: begin
                if (data_rvalid_i) begin
                    lsu_resp_valid_o = 1'b1;
                    lsu_resp_err_o   = data_err_i;
                    w_state_nxt      = LSU_IDLE;
                end
            end
            default: w_state_nxt = LSU_IDLE;
        endcase

        // Misaligned access rejected without touching the bus.
        if (r_err_pend) begin
            lsu_resp_valid_o = 1'b1;
            lsu_resp_err_o   = 1'b1;
        end

        rf_we_lsu_o    = lsu_resp_valid_o && !r_we && !lsu_resp_err_o;
        rf_wdata_lsu_o = rf_we_lsu_o ? w_ext : '0;
    end

endmodule

// File: tb/tb_qcv_lsu.sv
// Self-checking bench for qcv_lsu: directed cases plus randomized accesses
// compared against a byte-level memory-view reference model.
module tb_qcv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, sgn, gnt, rvalid, derr;
    logic [1:0]  typ;
    logic [31:0] addr, wd, rdata;

    logic        busy, dreq, dwe, rfwe, rv, re;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwdata, rfw;

    logic        busy0, dreq0, dwe0, rfwe0, rv0, re0;
    logic [3:0]  dbe0;
    logic [31:0] daddr0, dwdata0, rfw0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qcv_lsu #(.MISALIGNED_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_type_i(typ),
        .lsu_sign_ext_i(sgn), .lsu_addr_i(addr), .lsu_wdata_i(wd), .lsu_busy_o(busy),
        .data_req_o(dreq), .data_gnt_i(gnt), .data_addr_o(daddr), .data_we_o(dwe),
        .data_be_o(dbe), .data_wdata_o(dwdata), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .data_err_i(derr), .rf_wdata_lsu_o(rfw), .rf_we_lsu_o(rfwe),
        .lsu_resp_valid_o(rv), .lsu_resp_err_o(re)
    );

    qcv_lsu #(.MISALIGNED_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_type_i(typ),
        .lsu_sign_ext_i(sgn), .lsu_addr_i(addr), .lsu_wdata_i(wd), .lsu_busy_o(busy0),
        .data_req_o(dreq0), .data_gnt_i(gnt), .data_addr_o(daddr0), .data_we_o(dwe0),
        .data_be_o(dbe0), .data_wdata_o(dwdata0), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .data_err_i(derr), .rf_wdata_lsu_o(rfw0), .rf_we_lsu_o(rfwe0),
        .lsu_resp_valid_o(rv0), .lsu_resp_err_o(re0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),   32'd0);
        chk({tag, "_req"},   32'(dreq),   32'd0);
        chk({tag, "_addr"},  daddr,       32'd0);
        chk({tag, "_be"},    32'(dbe),    32'd0);
        chk({tag, "_we"},    32'(dwe),    32'd0);
        chk({tag, "_wdata"}, dwdata,      32'd0);
        chk({tag, "_rv"},    32'(rv),     32'd0);
        chk({tag, "_re"},    32'(re),     32'd0);
        chk({tag, "_rfwe"},  32'(rfwe),   32'd0);
        chk({tag, "_rfw"},   rfw,         32'd0);
    endtask

    // One bus transaction; called with inputs changing just after a negedge.
    task automatic bus_part(input string tag, input logic [31:0] a, input logic [3:0] be,
                            input logic w, input logic [31:0] wrot, input int gdly, input int rdly,
                            input logic [31:0] rd, input logic e, input logic fin,
                            input logic [31:0] ld);
        for (int k = 0; k <= gdly; k++) begin
            #1;
            chk({tag, "_req"},   32'(dreq), 32'd1);
            chk({tag, "_addr"},  daddr,     a);
            chk({tag, "_be"},    32'(dbe),  32'(be));
            chk({tag, "_we"},    32'(dwe),  32'(w));
            chk({tag, "_wdata"}, dwdata,    wrot);
            chk({tag, "_rvq"},   32'(rv),   32'd0);
            if (k == gdly) gnt = 1'b1;
            @(negedge clk);
            gnt = 1'b0;
        end
        req = 1'b0;
        for (int k = 0; k < rdly; k++) begin
            #1;
            chk({tag, "_req_off"}, 32'(dreq), 32'd0);
            chk({tag, "_rv_wait"}, 32'(rv),   32'd0);
            @(negedge clk);
        end
        rvalid = 1'b1;
        rdata  = rd;
        derr   = e;
        #1;
        chk({tag, "_req_rv"}, 32'(dreq), 32'd0);
        if (fin) begin
            chk({tag, "_rv"},   32'(rv),   32'd1);
            chk({tag, "_re"},   32'(re),   32'(e));
            chk({tag, "_rfwe"}, 32'(rfwe), 32'(!w && !e));
            chk({tag, "_rfw"},  rfw,       (!w && !e) ? ld : 32'd0);
        end else begin
            chk({tag, "_rv_mid"}, 32'(rv), 32'd0);
        end
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = $urandom;
        derr   = 1'b0;
    endtask

    // Reference model: views the access as a run of bytes in little-endian memory.
    task automatic do_access(input string tag, input logic w, input logic [1:0] t, input logic s,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd1,
                             input logic [31:0] rd2, input int gdly, input int rdly,
                             input logic e1, input logic e2, input logic poke);
        int          off, sz;
        logic        split;
        logic [3:0]  be1, be2;
        logic [31:0] a1, a2, wrot, ld;

        off = int'(a[1:0]);
        sz  = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
        split = (off + sz > 4);
        a1 = a & 32'hFFFF_FFFC;
        a2 = a1 + 32'd4;
        be1 = '0;
        be2 = '0;
        ld  = '0;
        for (int i = 0; i < sz; i++) begin
            if (off + i < 4) begin
                be1[off + i] = 1'b1;
                ld[8*i +: 8] = rd1[8*(off + i) +: 8];
            end else begin
                be2[off + i - 4] = 1'b1;
                ld[8*i +: 8] = rd2[8*(off + i - 4) +: 8];
            end
        end
        if (s && sz == 1 && ld[7])  ld[31:8]  = '1;
        if (s && sz == 2 && ld[15]) ld[31:16] = '1;
        for (int l = 0; l < 4; l++) wrot[8*l +: 8] = d[8*((l - off + 4) % 4) +: 8];

        req = 1'b1; we = w; typ = t; sgn = s; addr = a; wd = d;
        #1;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        req = poke;
        if (poke) begin
            addr = $urandom;
            we   = ~w;
            wd   = $urandom;
        end
        bus_part({tag, "_p1"}, a1, be1, w, wrot, gdly, rdly, rd1, e1, e1 || !split, ld);
        if (split && !e1)
            bus_part({tag, "_p2"}, a2, be2, w, wrot, gdly, rdly, rd2, e2, 1'b1, ld);
        #1;
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_req_end"},  32'(dreq), 32'd0);
        chk({tag, "_rv_end"},   32'(rv),   32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; typ = 2'b00; sgn = 1'b0; addr = '0; wd = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; derr = 1'b0;
        #1;
        chk_idle_outputs("reset");
        #11 rst = 1'b0;
        @(negedge clk);

        do_access("wload",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_access("bload_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0);
        do_access("bload_u", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 32'h0, 1, 0, 1'b0, 1'b0, 1'b0);
        do_access("mstore",  1'b1, 2'b10, 1'b0, 32'h0FE, 32'h11223344, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_access("hwrap",   1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hAB000000, 32'h000000CD, 0, 0, 1'b0, 1'b0, 1'b0);
        do_access("p1err",   1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h12345678, 32'h0, 0, 1, 1'b1, 1'b0, 1'b0);
        do_access("p2err",   1'b0, 2'b10, 1'b1, 32'h201, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1'b0, 1'b1, 1'b0);
        do_access("hold",    1'b0, 2'b01, 1'b1, 32'h042, 32'h0, 32'h8001CAFE, 32'h0, 5, 0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an access, then a stale response.
        req = 1'b1; we = 1'b0; typ = 2'b10; sgn = 1'b0; addr = 32'h200;
        @(negedge clk);
        req = 1'b0;
        gnt = 1'b1;
        #1 chk("rst_gnt_req", 32'(dreq), 32'd1);
        @(negedge clk);
        gnt = 1'b0;
        #1 chk("rst_in_rv1", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        #2 rst = 1'b0;
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h55AA55AA;
        #1;
        chk("stale_rv",   32'(rv),   32'd0);
        chk("stale_rfwe", 32'(rfwe), 32'd0);
        chk("stale_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk_idle_outputs("stale_after");
        @(negedge clk);

        // Misaligned word with splitting disabled: immediate error, no bus access.
        req = 1'b1; we = 1'b0; typ = 2'b10; sgn = 1'b0; addr = 32'h101;
        #1 chk("noen_req0", 32'(dreq0), 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("noen_rv",   32'(rv0),   32'd1);
        chk("noen_re",   32'(re0),   32'd1);
        chk("noen_rfwe", 32'(rfwe0), 32'd0);
        chk("noen_req1", 32'(dreq0), 32'd0);
        chk("noen_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        #1;
        chk("noen_rv_off", 32'(rv0),   32'd0);
        chk("noen_req2",   32'(dreq0), 32'd0);
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            do_access("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qcv_lsu.md
Name: qcv_lsu

Overview:
Load/store unit between the ID/EX stage and write-back. Accepts one load/store per request from ID and drives a req/gnt/rvalid data-memory port. Misaligned accesses are split into two word transactions. The unit aligns and sign/zero-extends load data and hands a single-cycle response (data, write enable, valid, error) to the WB stage. Only one access is outstanding at a time, and ID stalls on lsu_busy_o.

Parameters:
MISALIGNED_EN, 1, 1: misaligned accesses are split into two bus transactions; 0: misaligned accesses return an immediate error with no bus access.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
lsu_req_i  in  1  access request from ID (sampled only in IDLE)
lsu_we_i  in  1  1=store, 0=load
lsu_type_i  in  2  00=byte, 01=half, 10=word (11 reserved, treated as word)
lsu_sign_ext_i  in  1  sign-extend load data
lsu_addr_i  in  32  byte address
lsu_wdata_i  in  32  store data, LSB-justified
lsu_busy_o  out  1  unit not IDLE; ID must stall
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned bus address
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  bus write data
data_rvalid_i  in  1  bus response valid
data_rdata_i  in  32  bus read data
data_err_i  in  1  bus error, qualified by data_rvalid_i
rf_wdata_lsu_o  out  32  extended load data to WB
rf_we_lsu_o  out  1  register write enable to WB
lsu_resp_valid_o  out  1  access complete pulse
lsu_resp_err_o  out  1  access failed, qualified by lsu_resp_valid_o

Behaviour:
- Reset: state=IDLE. All outputs are 0, including data_be_o and data_addr_o. Reset mid-access abandons the access. A stale rvalid arriving after reset is ignored.
- States: IDLE, GNT1, RV1, GNT2, RV2.
- IDLE:
  - lsu_req_i=1 latches addr/we/type/sign/wdata and computes off=addr[1:0].
  - split = (half and off=3) or (word and off!=0).
  - If split and MISALIGNED_EN=0: one cycle later, pulse lsu_resp_valid_o=1 with lsu_resp_err_o=1. No bus access.
  - Otherwise go to GNT1. The bus request starts the cycle after acceptance.
- GNT1/GNT2:
  - data_req_o=1. Address, we, be and wdata stay stable until data_gnt_i=1.
  - On grant, go to RV1/RV2 and drop data_req_o the next cycle.
- RV1/RV2: wait for data_rvalid_i. Valid and grant are never both counted in the same state; rvalid arrives at least 1 cycle after grant.
- RV1 on rvalid:
  - err=1: respond with error and skip part 2.
  - split: store rdata1, go to GNT2.
  - Otherwise: respond.
- RV2 on rvalid: respond. Error reflects data_err_i of part 2.
- Response:
  - Same cycle as the final rvalid: lsu_resp_valid_o=1 for exactly one cycle, then IDLE.
  - rf_we_lsu_o = valid & load & !err.
  - rf_wdata_lsu_o is valid only with rf_we_lsu_o; otherwise it is 0.
  - Minimum latency: accept at cycle 0, req at 1, grant at 1, rvalid at 2, so response at cycle 2 and IDLE again at cycle 3.
- lsu_busy_o = (state != IDLE). lsu_req_i while busy is ignored.
- Addresses:
  - Part 1: data_addr_o = {addr[31:2],2'b00}.
  - Part 2: data_addr_o = part-1 address + 4, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000).
- Byte enables:
  - Byte: 0001<<off.
  - Half: 0011<<off; at off=3, part 1 = 1000 and part 2 = 0001.
  - Word: part 1 = (1111<<off)&1111; part 2 = 1111>>(4-off).
- data_wdata_o = lsu_wdata rotated left by 8*off, identical in both parts.
- Load data:
  - raw = ({rdata2,rdata1} >> 8*off)[31:0]. Unsplit accesses use rdata2=0.
  - Byte: raw[7:0] extended; half: raw[15:0] extended; word: raw.
  - Extension is sign when lsu_sign_ext_i=1, else zero.
- Stores never assert rf_we_lsu_o but do pulse lsu_resp_valid_o.

Decomposition:
- qcv_pkg holds:
  - LSU type encodings (LSU_TYPE_B/H/W).
  - The LSU state enum.
  - Byte-enable and width constants.
- qcv_lsu_align, a combinational sub-module, is natural:
  - Inputs: type, off, part select.
  - Outputs: be, rotated wdata, and extended rdata from {rdata2,rdata1}.
- The FSM, latches and bus handshake stay in qcv_lsu.

Test Plan:
- Aligned word load, addr 0x100, rdata 0xDEADBEEF, grant at cycle 1, rvalid at cycle 2 -> be=1111, resp_valid pulse at cycle 2, rf_we=1, wdata=0xDEADBEEF.
- Signed byte load, addr 0x103, rdata 0x80000000 -> be=1000, rf_wdata=0xFFFFFF80. The same access unsigned -> 0x00000080.
- Misaligned word store, addr 0x0FE, wdata 0x11223344 -> two bus transactions:
  - Part 1: addr 0x0FC, be=1100, wdata 0x33441122.
  - Part 2: addr 0x100, be=0011, same wdata.
  - Then one resp_valid with rf_we=0.
- Misaligned half load, addr 0xFFFFFFFF, rdata1 0xAB000000, rdata2 0x000000CD, signed -> part-2 address wraps to 0x00000000, rf_wdata=0xFFFFCDAB.
- Error on part 1 of a split load -> no GNT2 request, resp_valid=1, resp_err=1, rf_we=0. With MISALIGNED_EN=0, addr 0x101 word -> error one cycle after accept and data_req_o never asserted.
- Grant held off 5 cycles with lsu_req_i re-asserted while busy -> addr/be stable, second request ignored. Async rst_i during RV1, then a stale rvalid -> outputs 0, state IDLE, no response.
